// File: rtl/fp_pkg.sv
// Shared state encoding and binary32 constants for the sequential floating-point adder.
package fp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL,
        ALIGN,
        ADD_0,
        ADD_1,
        NORMALISE_1,
        NORMALISE_2,
        ROUND,
        PACK,
        PUT_Z
    } fp_state_e;

    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] EXP_MIN = -10'sd126;
    localparam logic signed [9:0] EXP_MAX = 10'sd127;
    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]       INF     = 32'h7F80_0000;

    // Zero and denormals share the minimum exponent; their hidden bit is cleared separately.
    function automatic logic signed [9:0] unbiasExp(input logic [7:0] field);
        if (field == 8'd0) begin
            return EXP_MIN;
        end
        return $signed({2'b00, field}) - BIAS;
    endfunction

endpackage

// File: rtl/fp_adder_if.sv
// Operand and result handshake bundle between the producer/consumer and the adder.
interface fp_adder_if;

    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_a_stb;
    logic        input_b_stb;
    logic        ack_output;
    logic        start;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        input_a_ack;
    logic        input_b_ack;

    modport slave (
        input  input_a,
        input  input_b,
        input  input_a_stb,
        input  input_b_stb,
        input  ack_output,
        input  start,
        output output_z,
        output output_z_stb,
        output input_a_ack,
        output input_b_ack
    );

    modport master (
        output input_a,
        output input_b,
        output input_a_stb,
        output input_b_stb,
        output ack_output,
        output start,
        input  output_z,
        input  output_z_stb,
        input  input_a_ack,
        input  input_b_ack
    );

endinterface

// File: rtl/fp_adder.sv
// Multi-cycle binary32 adder: one FSM walks each operand pair through unpack, align,
// add, normalise, round-to-nearest-even and pack, with strobe/ack handshakes at both ends.
module fp_adder
    import fp_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    fp_adder_if.slave bus
);

    fp_state_e          state_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [26:0]        aMant_q;
    logic [26:0]        bMant_q;
    logic signed [9:0]  aExp_q;
    logic signed [9:0]  bExp_q;
    logic               aSign_q;
    logic               bSign_q;
    logic [27:0]        sum_q;
    logic [23:0]        zMant_q;
    logic signed [9:0]  zExp_q;
    logic               zSign_q;
    logic               guard_q;
    logic               round_q;
    logic               sticky_q;
    logic [31:0]        outZ_q;
    logic               outStb_q;
    logic               aAck_q;
    logic               bAck_q;

    logic               aNan;
    logic               bNan;
    logic               aInf;
    logic               bInf;
    logic               aZero;
    logic               bZero;
    logic               isSpecial_d;
    logic [31:0]        specialZ_d;
    logic [27:0]        sum_d;
    logic               sumSign_d;
    logic [7:0]         biasedExp_d;
    logic [31:0]        packed_d;

    assign bus.output_z     = outZ_q;
    assign bus.output_z_stb = outStb_q;
    assign bus.input_a_ack  = aAck_q;
    assign bus.input_b_ack  = bAck_q;

    assign aNan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign bNan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign aInf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign bInf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign aZero = (a_q[30:0] == 31'd0);
    assign bZero = (b_q[30:0] == 31'd0);

    // Priority order matters: NaN beats infinity, which beats the zero shortcuts.
    always_comb begin
        isSpecial_d = 1'b1;
        specialZ_d  = QNAN;
        if (aNan || bNan) begin
            specialZ_d = QNAN;
        end else if (aInf) begin
            specialZ_d = (bInf && (a_q[31] != b_q[31])) ? QNAN : a_q;
        end else if (bInf) begin
            specialZ_d = b_q;
        end else if (aZero && bZero) begin
            specialZ_d = {a_q[31] & b_q[31], 31'd0};
        end else if (aZero) begin
            specialZ_d = b_q;
        end else if (bZero) begin
            specialZ_d = a_q;
        end else begin
            isSpecial_d = 1'b0;
        end
    end

    // Unlike signs subtract the smaller magnitude; the result takes the larger one's sign.
    always_comb begin
        sum_d     = '0;
        sumSign_d = aSign_q;
        if (aSign_q == bSign_q) begin
            sum_d = {1'b0, aMant_q} + {1'b0, bMant_q};
        end else if (aMant_q >= bMant_q) begin
            sum_d = {1'b0, aMant_q - bMant_q};
        end else begin
            sum_d     = {1'b0, bMant_q - aMant_q};
            sumSign_d = bSign_q;
        end
    end

    always_comb begin
        biasedExp_d = 8'(zExp_q + BIAS);
        packed_d    = {zSign_q, biasedExp_d, zMant_q[22:0]};
        if ((zExp_q == EXP_MIN) && !zMant_q[23]) begin
            packed_d[30:23] = 8'd0;
        end
        if (zExp_q > EXP_MAX) begin
            packed_d = INF | {zSign_q, 31'd0};
        end
        if (zMant_q == 24'd0) begin
            packed_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            aMant_q  <= '0;
            bMant_q  <= '0;
            aExp_q   <= '0;
            bExp_q   <= '0;
            aSign_q  <= 1'b0;
            bSign_q  <= 1'b0;
            sum_q    <= '0;
            zMant_q  <= '0;
            zExp_q   <= '0;
            zSign_q  <= 1'b0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            outZ_q   <= '0;
            outStb_q <= 1'b0;
            aAck_q   <= 1'b0;
            bAck_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start == 1'b1) begin
                        aAck_q  <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                GET_A: begin
                    if (aAck_q && bus.input_a_stb) begin
                        a_q     <= bus.input_a;
                        aAck_q  <= 1'b0;
                        bAck_q  <= 1'b1;
                        state_q <= GET_B;
                    end
                end
                GET_B: begin
                    if (bAck_q && bus.input_b_stb) begin
                        b_q     <= bus.input_b;
                        bAck_q  <= 1'b0;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    aMant_q <= {|a_q[30:23], a_q[22:0], 3'b000};
                    bMant_q <= {|b_q[30:23], b_q[22:0], 3'b000};
                    aExp_q  <= unbiasExp(a_q[30:23]);
                    bExp_q  <= unbiasExp(b_q[30:23]);
                    aSign_q <= a_q[31];
                    bSign_q <= b_q[31];
                    state_q <= SPECIAL;
                end
                SPECIAL: begin
                    if (isSpecial_d) begin
                        outZ_q   <= specialZ_d;
                        outStb_q <= 1'b1;
                        state_q  <= PUT_Z;
                    end else begin
                        state_q <= ALIGN;
                    end
                end
                // Bit 0 acts as the sticky bit while the smaller operand is shifted down.
                ALIGN: begin
                    if (aExp_q > bExp_q) begin
                        bExp_q  <= bExp_q + 10'sd1;
                        bMant_q <= {1'b0, bMant_q[26:2], bMant_q[1] | bMant_q[0]};
                    end else if (aExp_q < bExp_q) begin
                        aExp_q  <= aExp_q + 10'sd1;
                        aMant_q <= {1'b0, aMant_q[26:2], aMant_q[1] | aMant_q[0]};
                    end else begin
                        state_q <= ADD_0;
                    end
                end
                ADD_0: begin
                    sum_q   <= sum_d;
                    zSign_q <= sumSign_d;
                    zExp_q  <= aExp_q;
                    state_q <= ADD_1;
                end
                ADD_1: begin
                    if (sum_q[27]) begin
                        zMant_q  <= sum_q[27:4];
                        guard_q  <= sum_q[3];
                        round_q  <= sum_q[2];
                        sticky_q <= sum_q[1] | sum_q[0];
                        zExp_q   <= zExp_q + 10'sd1;
                    end else begin
                        zMant_q  <= sum_q[26:3];
                        guard_q  <= sum_q[2];
                        round_q  <= sum_q[1];
                        sticky_q <= sum_q[0];
                    end
                    state_q <= NORMALISE_1;
                end
                NORMALISE_1: begin
                    if (!zMant_q[23] && (zExp_q > EXP_MIN)) begin
                        zExp_q  <= zExp_q - 10'sd1;
                        zMant_q <= {zMant_q[22:0], guard_q};
                        guard_q <= round_q;
                        round_q <= 1'b0;
                    end else begin
                        state_q <= NORMALISE_2;
                    end
                end
                NORMALISE_2: begin
                    if (zExp_q < EXP_MIN) begin
                        zExp_q   <= zExp_q + 10'sd1;
                        zMant_q  <= {1'b0, zMant_q[23:1]};
                        guard_q  <= zMant_q[0];
                        round_q  <= guard_q;
                        sticky_q <= sticky_q | round_q;
                    end else begin
                        state_q <= ROUND;
                    end
                end
                // A carry out of the mantissa becomes 1.0 at the next exponent.
                ROUND: begin
                    if (guard_q && (round_q || sticky_q || zMant_q[0])) begin
                        if (zMant_q == 24'hFF_FFFF) begin
                            zMant_q <= 24'h80_0000;
                            zExp_q  <= zExp_q + 10'sd1;
                        end else begin
                            zMant_q <= zMant_q + 24'd1;
                        end
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    outZ_q   <= packed_d;
                    outStb_q <= 1'b1;
                    state_q  <= PUT_Z;
                end
                PUT_Z: begin
                    if (outStb_q && bus.ack_output) begin
                        outStb_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_adder.sv
// Self-checking bench for fp_adder: directed vectors, handshake and reset corner cases,
// and random operands checked against an exact wide-integer binary32 addition model.
module tb_fp_adder;
    import fp_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vector_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   bothAckCount = 0;
    int   aAckFirst = -1;
    int   bAckFirst = -1;

    fp_adder_if bus();

    fp_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Tracks which ack appears first and flags any cycle where both are raised together.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (bus.input_a_ack && bus.input_b_ack) bothAckCount <= bothAckCount + 1;
        if (bus.input_a_ack && aAckFirst < 0) aAckFirst <= cycle;
        if (bus.input_b_ack && bAckFirst < 0) bAckFirst <= cycle;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Magnitude of a finite binary32 value as an integer count of 2^-149 units.
    function automatic logic [299:0] wideMag(input logic [31:0] x);
        logic [299:0] m;
        if (x[30:23] == 8'd0) begin
            m = {277'd0, x[22:0]};
        end else begin
            m = {276'd0, 1'b1, x[22:0]};
            m = m << (int'(x[30:23]) - 1);
        end
        return m;
    endfunction

    function automatic logic [31:0] roundPack(input logic sign, input logic [299:0] mag);
        int           p;
        int           shift;
        int           field;
        logic [299:0] one;
        logic [299:0] shifted;
        logic [299:0] rem;
        logic [299:0] half;
        logic [24:0]  keep;
        logic         roundUp;
        p = 0;
        for (int i = 0; i < 300; i++) begin
            if (mag[i]) p = i;
        end
        if (p < 24) begin
            return {sign, 7'd0, mag[23:0]};
        end
        one     = 300'd1;
        shift   = p - 23;
        shifted = mag >> shift;
        keep    = {1'b0, shifted[23:0]};
        rem     = mag & ((one << shift) - one);
        half    = one << (shift - 1);
        roundUp = (rem > half) || ((rem == half) && keep[0]);
        keep    = keep + {24'd0, roundUp};
        if (keep[24]) begin
            keep  = keep >> 1;
            shift = shift + 1;
        end
        field = shift + 1;
        if (field >= 255) begin
            return INF | {sign, 31'd0};
        end
        return {sign, 8'(field), keep[22:0]};
    endfunction

    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        logic         aNan;
        logic         bNan;
        logic         aInf;
        logic         bInf;
        logic [299:0] ma;
        logic [299:0] mb;
        logic [299:0] mag;
        logic         sign;
        aNan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bNan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        aInf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bInf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (aNan || bNan) return QNAN;
        if (aInf) return (bInf && (a[31] != b[31])) ? QNAN : a;
        if (bInf) return b;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return {a[31] & b[31], 31'd0};
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        ma = wideMag(a);
        mb = wideMag(b);
        if (a[31] == b[31]) begin
            mag  = ma + mb;
            sign = a[31];
        end else if (ma >= mb) begin
            mag  = ma - mb;
            sign = a[31];
        end else begin
            mag  = mb - ma;
            sign = b[31];
        end
        if (mag == 300'd0) return 32'd0;
        return roundPack(sign, mag);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic loadOperands(input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n;
        ok = 1'b0;
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        n = 0;
        while (!bus.input_a_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.input_a_ack) begin
            bus.input_a_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.input_a_stb = 1'b0;
        bus.input_b     = b;
        bus.input_b_stb = 1'b1;
        n = 0;
        while (!bus.input_b_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.input_b_ack) begin
            bus.input_b_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.input_b_stb = 1'b0;
        ok = 1'b1;
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expZ, input int holdCycles);
        bit ok;
        int n;
        loadOperands(a, b, ok);
        checkOutput({name, "_load"}, {31'd0, ok}, 32'd1);
        if (!ok) begin
            pulseReset();
            return;
        end
        n = 0;
        while (!bus.output_z_stb && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done"}, {31'd0, bus.output_z_stb}, 32'd1);
        if (!bus.output_z_stb) begin
            pulseReset();
            return;
        end
        checkOutput(name, bus.output_z, expZ);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({name, "_hold_stb"}, {31'd0, bus.output_z_stb}, 32'd1);
            checkOutput({name, "_hold_z"}, bus.output_z, expZ);
        end
        bus.ack_output = 1'b1;
        @(posedge clk);
        #1 bus.ack_output = 1'b0;
        checkOutput({name, "_stb_clear"}, {31'd0, bus.output_z_stb}, 32'd1 - 32'd1);
    endtask

    vector_t vectors [13];

    initial begin
        int          n;
        bit          ok;
        logic [31:0] ra;
        logic [31:0] rb;
        int          e;

        vectors[0]  = '{a: 32'h3F80_0000, b: 32'hBF80_0000, z: 32'h0000_0000};
        vectors[1]  = '{a: 32'h7F80_0000, b: 32'hFF80_0000, z: 32'h7FC0_0000};
        vectors[2]  = '{a: 32'h3F80_0000, b: 32'h3380_0000, z: 32'h3F80_0000};
        vectors[3]  = '{a: 32'h3F80_0001, b: 32'h3380_0000, z: 32'h3F80_0002};
        vectors[4]  = '{a: 32'h0000_0001, b: 32'h0000_0001, z: 32'h0000_0002};
        vectors[5]  = '{a: 32'h7F7F_FFFF, b: 32'h7F7F_FFFF, z: 32'h7F80_0000};
        vectors[6]  = '{a: 32'h7FA0_0000, b: 32'h3F80_0000, z: 32'h7FC0_0000};
        vectors[7]  = '{a: 32'h8000_0000, b: 32'h8000_0000, z: 32'h8000_0000};
        vectors[8]  = '{a: 32'h0000_0000, b: 32'h8000_0000, z: 32'h0000_0000};
        vectors[9]  = '{a: 32'h40A0_0000, b: 32'hFF80_0000, z: 32'hFF80_0000};
        vectors[10] = '{a: 32'h007F_FFFF, b: 32'h0000_0001, z: 32'h0080_0000};
        vectors[11] = '{a: 32'h4000_0000, b: 32'hBFC0_0000, z: 32'h3F00_0000};
        vectors[12] = '{a: 32'h0080_0000, b: 32'h8000_0001, z: 32'h007F_FFFF};

        bus.start       = 1'b1;
        bus.input_a_stb = 1'b1;
        bus.input_b_stb = 1'b1;
        bus.ack_output  = 1'b1;
        bus.input_a     = 32'h417C_0000;
        bus.input_b     = 32'h40E8_0000;
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_z", bus.output_z, 32'd0);
        checkOutput("reset_stb", {31'd0, bus.output_z_stb}, 32'd0);
        checkOutput("reset_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
        checkOutput("reset_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Everything held high from reset release: the first sum must appear quickly.
        n = 0;
        while (!bus.output_z_stb && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_within_60", {31'd0, bus.output_z_stb}, 32'd1);
        checkOutput("first_z", bus.output_z, 32'h41B8_0000);
        bus.input_a_stb = 1'b0;
        bus.input_b_stb = 1'b0;
        @(posedge clk);
        #1 checkOutput("first_stb_pulse", {31'd0, bus.output_z_stb}, 32'd0);
        bus.ack_output = 1'b0;
        checkOutput("a_ack_before_b_ack", {31'd0, (aAckFirst >= 0) && (aAckFirst < bAckFirst)}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].z, 0);
        end

        applyStimulus("hold_ack", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 4);
        @(posedge clk);
        #1 checkOutput("reenter_get_a", {31'd0, bus.input_a_ack}, 32'd1);

        // Huge exponent gap keeps the block in ALIGN long enough to reset it there.
        loadOperands(32'h7F00_0000, 32'h0000_0001, ok);
        checkOutput("align_load", {31'd0, ok}, 32'd1);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_z", bus.output_z, 32'd0);
        checkOutput("async_reset_stb", {31'd0, bus.output_z_stb}, 32'd0);
        checkOutput("async_reset_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
        checkOutput("async_reset_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("post_reset", 32'h7F00_0000, 32'h0000_0001, 32'h7F00_0000, 0);

        for (int i = 0; i < 100; i++) begin
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                e = int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3;
                if (e < 0) e = 0;
                if (e > 254) e = 254;
                rb[30:23] = 8'(e);
            end
            if ($urandom_range(0, 7) == 0) begin
                rb = {~ra[31], ra[30:0]};
            end
            applyStimulus($sformatf("rand%0d", i), ra, rb, refAdd(ra, rb), 0);
        end

        checkOutput("ack_exclusive", 32'(bothAckCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
